// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversamples SCL/SDA on clk, detects START/STOP, matches the
// 7-bit address, ACKs, decodes the SSD1306-style control byte and emits tagged payload bytes.
module i2c_slave_rx #(
  parameter logic [6:0]  I2C_ADDR = 7'h3C,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_is_cmd,
  output logic       rx_valid,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);

  // Line index 1 = SCL, 0 = SDA throughout the input path.
  logic [1:0] sync0, sync1;
  logic [1:0] line_f, line_q;
  logic [3:0] filt_cnt [2];

  logic scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, start_c, stop_c;

  state_t     state, state_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic       bit_pend, bit_pend_d;
  logic [7:0] shreg, shreg_d;
  logic       co, co_d, dc, dc_d;
  logic       sda_oe, sda_oe_d;
  logic [7:0] rx_data_d;
  logic       rx_is_cmd_d, rx_valid_d, busy_d, err_d;
  logic       in_byte, byte_done;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // NOTE: every clocked process uses non-blocking assignments so all flops update
  // together from pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 2'b11;
      sync1 <= 2'b11;
    end else begin
      sync0 <= {scl, sda};
      sync1 <= sync0;
    end
  end

  // A new level is accepted only after FILT_LEN consecutive samples disagree with the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_f <= 2'b11;
      line_q <= 2'b11;
      for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
    end else begin
      line_q <= line_f;
      for (int i = 0; i < 2; i++) begin
        if (sync1[i] == line_f[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_MAX) begin
          line_f[i]   <= sync1[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign scl_f    = line_f[1];
  assign sda_f    = line_f[0];
  assign scl_q    = line_q[1];
  assign sda_q    = line_q[0];
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

  // A bit is sampled on the rise but only counted once SCL falls, so the rise that
  // precedes a STOP never makes a clean byte boundary look like a partial byte.
  assign in_byte   = (state == ADDR) || (state == CTRL) || (state == DATA);
  assign byte_done = in_byte && scl_fall && bit_pend && (bit_cnt == 3'd7);

  always_comb begin
    // NOTE: every combinational output gets a default first; any path that skipped an
    // assignment would otherwise infer a latch.
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    bit_pend_d  = bit_pend;
    shreg_d     = shreg;
    co_d        = co;
    dc_d        = dc;
    sda_oe_d    = sda_oe;
    rx_data_d   = rx_data;
    rx_is_cmd_d = rx_is_cmd;
    rx_valid_d  = 1'b0;
    busy_d      = busy;
    err_d       = err;

    if (start_c) begin
      state_d    = ADDR;
      bit_cnt_d  = '0;
      bit_pend_d = 1'b0;
      sda_oe_d   = 1'b0;
      err_d      = 1'b0;
    end else if (stop_c) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      bit_pend_d = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      if (in_byte && (bit_cnt != 3'd0)) err_d = 1'b1;
    end else begin
      if (in_byte) begin
        if (scl_rise) begin
          shreg_d    = {shreg[6:0], sda_f};
          bit_pend_d = 1'b1;
        end else if (scl_fall && bit_pend) begin
          bit_pend_d = 1'b0;
          bit_cnt_d  = bit_cnt + 3'd1;  // wraps to 0 on the eighth bit
        end
      end

      case (state)
        ADDR: begin
          if (byte_done) begin
            if (shreg == {I2C_ADDR, 1'b0}) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
              if (shreg[7:1] == I2C_ADDR) err_d = 1'b1;
            end
          end
        end
        CTRL: begin
          if (byte_done) begin
            co_d     = shreg[7];
            dc_d     = shreg[6];
            sda_oe_d = 1'b1;
            state_d  = CTRL_ACK;
          end
        end
        DATA: begin
          if (byte_done) begin
            rx_data_d   = shreg;
            rx_is_cmd_d = ~dc;
            rx_valid_d  = 1'b1;
            sda_oe_d    = 1'b1;
            state_d     = DATA_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = CTRL;
          end
        end
        CTRL_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = DATA;
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = co ? CTRL : DATA;
          end
        end
        IDLE, IGNORE: sda_oe_d = 1'b0;
        default:      state_d  = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_pend  <= 1'b0;
      shreg     <= '0;
      co        <= 1'b0;
      dc        <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_is_cmd <= 1'b0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      bit_pend  <= bit_pend_d;
      shreg     <= shreg_d;
      co        <= co_d;
      dc        <= dc_d;
      sda_oe    <= sda_oe_d;
      rx_data   <= rx_data_d;
      rx_is_cmd <= rx_is_cmd_d;
      rx_valid  <= rx_valid_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: a bit-banged I2C master with an open-drain SDA bus, a
// transaction-level reference model, directed scenarios and random transactions.
module tb_i2c_slave_rx;

  localparam int         Q     = 10;  // quarter SCL period in clk cycles
  localparam logic [6:0] ADDR7 = 7'h3C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_drv = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_is_cmd, rx_valid, busy, err;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_rx #(.I2C_ADDR(ADDR7), .FILT_LEN(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl_drv),
    .sda       (sda_bus),
    .rx_data   (rx_data),
    .rx_is_cmd (rx_is_cmd),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         drive_cnt = 0;
  logic [8:0] got_q[$];
  logic [7:0] tx_q[$];
  bit         ack_exp_q[$];
  logic [8:0] exp_rx_q[$];
  bit         exp_err, exp_match;

  // Passive monitor: records every rx_valid cycle and counts cycles the target pulls SDA low.
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back({rx_is_cmd, rx_data});
    if (sda_bus === 1'b0 && !m_low) drive_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic i2c_start();
    if (!scl_drv) begin
      m_low = 1'b0; clk_n(Q);
      scl_drv = 1'b1; clk_n(Q);
    end
    m_low = 1'b1; clk_n(Q);
    scl_drv = 1'b0; clk_n(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; clk_n(Q);
    scl_drv = 1'b1; clk_n(Q);
    m_low = 1'b0; clk_n(2 * Q);
  endtask

  // One bit cell; optional glitches on SCL (low phase) and SDA (high phase), both 2 clk wide.
  task automatic send_bit(input logic b, input bit glitch, output logic sampled);
    m_low = ~b;
    if (glitch) begin
      clk_n(Q / 2); scl_drv = 1'b1; clk_n(2); scl_drv = 1'b0; clk_n(Q - Q / 2 - 2);
    end else begin
      clk_n(Q);
    end
    scl_drv = 1'b1;
    clk_n(Q / 2);
    if (glitch) begin
      m_low = b; clk_n(2); m_low = ~b; clk_n(Q / 2 - 2);
    end else begin
      clk_n(Q / 2);
    end
    sampled = sda_bus;
    clk_n(Q);
    scl_drv = 1'b0;
    clk_n(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output bit acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch, s);
    send_bit(1'b1, 1'b0, s);
    acked = (s === 1'b0);
  endtask

  // Reference: first byte addresses; once matched every byte is ACKed, control bytes set
  // Co/D-C#, data bytes are emitted tagged cmd = ~D/C#, Co=1 makes the next byte a control byte.
  task automatic model_txn();
    logic [7:0] a0, b;
    bit ctrl_next, co, dc;
    ack_exp_q.delete();
    exp_rx_q.delete();
    a0        = tx_q[0];
    exp_match = (a0 == {ADDR7, 1'b0});
    exp_err   = (a0[7:1] == ADDR7) && a0[0];
    ack_exp_q.push_back(exp_match);
    ctrl_next = 1'b1;
    co = 1'b0;
    dc = 1'b0;
    for (int i = 1; i < tx_q.size(); i++) begin
      b = tx_q[i];
      ack_exp_q.push_back(exp_match);
      if (exp_match) begin
        if (ctrl_next) begin
          co = b[7];
          dc = b[6];
          ctrl_next = 1'b0;
        end else begin
          exp_rx_q.push_back({~dc, b});
          ctrl_next = co;
        end
      end
    end
  endtask

  task automatic run_txn(input string tag, input bit glitch);
    int base, d0, n;
    bit a;
    model_txn();
    base = got_q.size();
    d0   = drive_cnt;
    i2c_start();
    check($sformatf("%s err_after_start", tag), 32'(err), 32'(0));
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], glitch, a);
      check($sformatf("%s ack%0d", tag, i), 32'(a), 32'(ack_exp_q[i]));
      if (i == 0) check($sformatf("%s busy_addr", tag), 32'(busy), 32'(exp_match));
    end
    i2c_stop();
    clk_n(4);
    check($sformatf("%s busy_end", tag), 32'(busy), 32'(0));
    check($sformatf("%s err_end", tag), 32'(err), 32'(exp_err));
    n = got_q.size() - base;
    check($sformatf("%s rx_count", tag), 32'(n), 32'(exp_rx_q.size()));
    for (int k = 0; k < n && k < exp_rx_q.size(); k++)
      check($sformatf("%s rx%0d", tag, k), 32'(got_q[base + k]), 32'(exp_rx_q[k]));
    if (!exp_match) check($sformatf("%s sda_untouched", tag), 32'(drive_cnt - d0), 32'(0));
  endtask

  initial begin
    int         base, nb, sel;
    bit         a;
    logic       s;
    logic [6:0] ra;
    logic [7:0] pat;

    clk_n(5);
    check("reset rx_data", 32'(rx_data), 32'(0));
    check("reset rx_is_cmd", 32'(rx_is_cmd), 32'(0));
    check("reset rx_valid", 32'(rx_valid), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset err", 32'(err), 32'(0));
    check("reset sda", 32'(sda_bus), 32'(1));
    rst = 1'b0;
    clk_n(10);

    tx_q = '{8'h78, 8'h00, 8'hAF};
    run_txn("t1", 1'b0);
    tx_q = '{8'h78, 8'h40, 8'h11, 8'h22, 8'h33};
    run_txn("t2", 1'b0);
    tx_q = '{8'h78, 8'h80, 8'hA5, 8'hC0, 8'h5A};
    run_txn("t3", 1'b0);
    tx_q = '{8'h7A, 8'h55, 8'hAA};
    run_txn("t4a", 1'b0);
    tx_q = '{8'h79};
    run_txn("t4b", 1'b0);

    // STOP after four data bits, then a repeated START in the middle of a data byte.
    pat = 8'hA5;
    i2c_start();
    send_byte(8'h78, 1'b0, a); check("t5 ack_addr", 32'(a), 32'(1));
    send_byte(8'h00, 1'b0, a); check("t5 ack_ctrl", 32'(a), 32'(1));
    base = got_q.size();
    for (int i = 7; i >= 4; i--) send_bit(pat[i], 1'b0, s);
    i2c_stop();
    clk_n(4);
    check("t5 err_partial", 32'(err), 32'(1));
    check("t5 busy_partial", 32'(busy), 32'(0));
    check("t5 rx_none", 32'(got_q.size() - base), 32'(0));
    i2c_start();
    send_byte(8'h78, 1'b0, a);
    send_byte(8'h00, 1'b0, a);
    for (int i = 7; i >= 5; i--) send_bit(pat[i], 1'b0, s);
    tx_q = '{8'h78, 8'h00, 8'h01};
    run_txn("t5b", 1'b0);

    tx_q = '{8'h78, 8'h40, 8'h3C, 8'hC3};
    run_txn("t6 glitch", 1'b1);

    // Reset pulse while the target holds the data-byte ACK.
    pat = 8'hAF;
    i2c_start();
    send_byte(8'h78, 1'b0, a);
    send_byte(8'h00, 1'b0, a);
    base = got_q.size();
    for (int i = 7; i >= 0; i--) send_bit(pat[i], 1'b0, s);
    m_low = 1'b0;
    check("t6 ack_held", 32'(sda_bus), 32'(0));
    check("t6 rx_before_rst", 32'(got_q.size() - base), 32'(1));
    if (got_q.size() > base) check("t6 rx_byte", 32'(got_q[base]), 32'({1'b1, pat}));
    rst = 1'b1;
    clk_n(1);
    check("t6 rst sda", 32'(sda_bus), 32'(1));
    check("t6 rst rx_data", 32'(rx_data), 32'(0));
    check("t6 rst rx_is_cmd", 32'(rx_is_cmd), 32'(0));
    check("t6 rst rx_valid", 32'(rx_valid), 32'(0));
    check("t6 rst busy", 32'(busy), 32'(0));
    check("t6 rst err", 32'(err), 32'(0));
    rst = 1'b0;
    scl_drv = 1'b1; clk_n(2 * Q);
    scl_drv = 1'b0; clk_n(Q);
    i2c_stop();
    clk_n(4);
    check("t6 post_rst err", 32'(err), 32'(0));
    check("t6 post_rst rx", 32'(got_q.size() - base), 32'(1));
    tx_q = '{8'h78, 8'h40, 8'h5A};
    run_txn("t6 resume", 1'b0);

    for (int t = 0; t < 16; t++) begin
      nb  = $urandom_range(1, 5);
      sel = $urandom_range(0, 9);
      tx_q.delete();
      if (sel <= 6) begin
        tx_q.push_back(8'h78);
      end else if (sel == 7) begin
        tx_q.push_back(8'h79);
      end else begin
        ra = 7'($urandom_range(0, 127));
        if (ra == ADDR7) ra = ra ^ 7'h01;
        tx_q.push_back({ra, 1'($urandom_range(0, 1))});
      end
      for (int k = 0; k < nb; k++) tx_q.push_back(8'($urandom));
      run_txn($sformatf("rnd%0d", t), (t % 4) == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
